// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, CSR addresses,
// mcause codes, mstatus/mie bit positions and the mstatus rewrite helpers.
package trap_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MSTATUS,
      W_MCAUSE,
      M_MSTATUS,
      JUMP
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
   localparam logic [31:0] CAUSE_SW     = 32'h8000_0003;
   localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
   localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
   localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   typedef struct packed {
      logic        valid;
      logic        is_mret;
      logic [31:0] cause;
   } trap_req_t;

   function automatic logic [31:0] csr_addr(input logic [11:0] a);
      return {20'h0, a};
   endfunction

   // Trap entry: stash MIE into MPIE, then mask interrupts.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
      logic [31:0] r;
      r = m;
      r[MSTATUS_MPIE] = m[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Return: restore MIE from MPIE, MPIE reads back as 1.
   function automatic logic [31:0] ret_mstatus(input logic [31:0] m);
      logic [31:0] r;
      r = m;
      r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_arb.sv
// Combinational priority pick of one trap event per cycle:
// ext > sw > timer > ecall > ebreak > mret.
module trap_arb
   import trap_ctrl_pkg::*;
(
   input  logic      inst_valid,
   input  logic      ecall,
   input  logic      ebreak,
   input  logic      mret,
   input  logic      irq_ext,
   input  logic      irq_sw,
   input  logic      irq_timer,
   input  logic      mstatus_mie,
   input  logic      mie_meie,
   input  logic      mie_msie,
   input  logic      mie_mtie,
   output trap_req_t req
);

   logic irq_ok;

   // Interrupts need a live instruction so there is a PC to save.
   assign irq_ok = mstatus_mie & inst_valid;

   always_comb begin
      req = '0;
      if (irq_ok && irq_ext && mie_meie) begin
         req.valid = 1'b1;
         req.cause = CAUSE_EXT;
      end else if (irq_ok && irq_sw && mie_msie) begin
         req.valid = 1'b1;
         req.cause = CAUSE_SW;
      end else if (irq_ok && irq_timer && mie_mtie) begin
         req.valid = 1'b1;
         req.cause = CAUSE_TIMER;
      end else if (inst_valid && ecall) begin
         req.valid = 1'b1;
         req.cause = CAUSE_ECALL;
      end else if (inst_valid && ebreak) begin
         req.valid = 1'b1;
         req.cause = CAUSE_EBREAK;
      end else if (inst_valid && mret) begin
         req.valid   = 1'b1;
         req.is_mret = 1'b1;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: stalls the pipe, writes mepc/mstatus/mcause one per cycle
// through the CSR clint port, then redirects to mtvec (trap) or mepc (mret).
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_addr_i,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        mret_i,
   input  logic        irq_ext_i,
   input  logic        irq_sw_i,
   input  logic        irq_timer_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   output logic        csr_we_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        stall_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o
);

   state_t      state_q, state_d;
   trap_req_t   req;
   logic [31:0] pc_q, cause_q, mstatus_q;
   logic        mret_q;
   logic        unused_bits;

   // Only the enable bits of mie and the aligned part of mtvec matter.
   assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};

   trap_arb u_arb (
      .inst_valid  (inst_valid_i),
      .ecall       (ecall_i),
      .ebreak      (ebreak_i),
      .mret        (mret_i),
      .irq_ext     (irq_ext_i),
      .irq_sw      (irq_sw_i),
      .irq_timer   (irq_timer_i),
      .mstatus_mie (mstatus_i[MSTATUS_MIE]),
      .mie_meie    (mie_i[MIE_MEIE]),
      .mie_msie    (mie_i[MIE_MSIE]),
      .mie_mtie    (mie_i[MIE_MTIE]),
      .req         (req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cause_q   <= '0;
         mstatus_q <= '0;
         mret_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req.valid) begin
            pc_q      <= inst_addr_i;
            cause_q   <= req.cause;
            mstatus_q <= mstatus_i;
            mret_q    <= req.is_mret;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      stall_o     = 1'b1;
      jump_o      = 1'b0;
      jump_addr_o = RESET_PC;
      case (state_q)
         IDLE: begin
            stall_o = req.valid;
            if (req.valid) state_d = req.is_mret ? M_MSTATUS : W_MEPC;
         end
         W_MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = csr_addr(CSR_MEPC);
            csr_wdata_o = pc_q;
            state_d     = W_MSTATUS;
         end
         W_MSTATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = csr_addr(CSR_MSTATUS);
            csr_wdata_o = trap_mstatus(mstatus_q);
            state_d     = W_MCAUSE;
         end
         W_MCAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = csr_addr(CSR_MCAUSE);
            csr_wdata_o = cause_q;
            state_d     = JUMP;
         end
         M_MSTATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = csr_addr(CSR_MSTATUS);
            csr_wdata_o = ret_mstatus(mstatus_q);
            state_d     = JUMP;
         end
         JUMP: begin
            // mtvec/mepc are read here so the CSR writes above have landed.
            jump_o      = 1'b1;
            jump_addr_o = mret_q ? mepc_i : {mtvec_i[31:2], 2'b00};
            state_d     = IDLE;
         end
         default: begin
            stall_o = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule
